slider_ray_gen: RTL

- Sequential, parametrised move generator for one piece per request.
- Given a source square and piece code, it walks each legal direction step by step. Each step reads the board through a synchronous read port. Each reachable target square is emitted on a valid/ready stream.
- Generalises the fixed 8-column combinational generator to any 2^COORD_W board. Adds knight/king modes, blocker/capture handling and backpressure.
- Sits between the board RAM and the move list buffer.

---
 rtl/slider_ray_gen_if.sv | 37 +++
 rtl/slider_ray_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/slider_ray_gen_if.sv
// Request, board-read and move-stream signals of the ray generator.
// master = generator side, slave = board RAM / move buffer / requester side.
interface slider_ray_gen_if #(
  parameter int COORD_W = 3,
  parameter int PIECE_W = 4,
  parameter int COUNT_W = 6
);
  logic               start;
  logic [COORD_W-1:0] src_x;
  logic [COORD_W-1:0] src_y;
  logic [PIECE_W-1:0] src_piece;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] move_count;
  logic               rd_en;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [PIECE_W-1:0] rd_piece;
  logic               mv_valid;
  logic               mv_ready;
  logic [COORD_W-1:0] mv_to_x;
  logic [COORD_W-1:0] mv_to_y;
  logic               mv_capture;
  logic [PIECE_W-1:0] mv_victim;

  modport master (
    input  start, src_x, src_y, src_piece, rd_piece, mv_ready,
    output busy, done, move_count, rd_en, rd_x, rd_y,
           mv_valid, mv_to_x, mv_to_y, mv_capture, mv_victim
  );

  modport slave (
    output start, src_x, src_y, src_piece, rd_piece, mv_ready,
    input  busy, done, move_count, rd_en, rd_x, rd_y,
           mv_valid, mv_to_x, mv_to_y, mv_capture, mv_victim
  );
endinterface

// File: rtl/slider_ray_gen.sv
// Sequential move generator: walks each enabled direction of one piece,
// probing the board through a synchronous read port and streaming targets.
//
// state    | meaning
// IDLE     | waiting for start
// NEXT_DIR | pick next enabled direction, cursor back to source
// STEP     | compute candidate, issue board read if on-board
// WAIT     | board data arrives, classify target square
// EMIT     | move held on stream until accepted
// FIN      | one-cycle done pulse
module slider_ray_gen #(
  parameter int COORD_W = 3,
  parameter int PIECE_W = 4,
  parameter int COUNT_W = 6
) (
  input logic            clk,
  input logic            rst,
  slider_ray_gen_if.master bus
);
  localparam int CW = COORD_W + 1;

  typedef enum logic [2:0] {IDLE, NEXT_DIR, STEP, WAIT, EMIT, FIN} state_t;
  state_t state, state_nxt;

  logic [COORD_W-1:0]    src_x_q, src_y_q, cur_x, cur_y, to_x, to_y;
  logic                  src_colour;
  logic [2:0]            src_type;
  logic [2:0]            dir, found_dir;
  logic [3:0]            dir_ptr;
  logic                  ray_end, found, jump, single, cand_ok, rd_en;
  logic                  capture;
  logic [7:0]            dir_mask;
  logic signed [CW-1:0]  dx, dy, cand_x, cand_y;
  logic [PIECE_W-1:0]    victim;
  logic [COUNT_W-1:0]    move_count;
  logic [2:0]            rd_type;
  logic                  rd_colour;

  function automatic logic signed [CW-1:0] off(input int v);
    return CW'(v);
  endfunction

  assign rd_type   = bus.rd_piece[2:0];
  assign rd_colour = bus.rd_piece[PIECE_W-1];

  always_comb begin
    dir_mask = 8'h00;
    jump     = 1'b0;
    single   = 1'b0;
    case (src_type)
      3'd2: begin dir_mask = 8'hFF; jump = 1'b1; single = 1'b1; end
      3'd3: dir_mask = 8'hAA;
      3'd4: dir_mask = 8'h55;
      3'd5: dir_mask = 8'hFF;
      3'd6: begin dir_mask = 8'hFF; single = 1'b1; end
      default: dir_mask = 8'h00;
    endcase
  end

  always_comb begin
    dx = '0;
    dy = '0;
    if (jump) begin
      case (dir)
        3'd0: begin dx = off(1);  dy = off(2);  end
        3'd1: begin dx = off(2);  dy = off(1);  end
        3'd2: begin dx = off(2);  dy = off(-1); end
        3'd3: begin dx = off(1);  dy = off(-2); end
        3'd4: begin dx = off(-1); dy = off(-2); end
        3'd5: begin dx = off(-2); dy = off(-1); end
        3'd6: begin dx = off(-2); dy = off(1);  end
        default: begin dx = off(-1); dy = off(2); end
      endcase
    end else begin
      case (dir)
        3'd0: begin dx = off(0);  dy = off(1);  end
        3'd1: begin dx = off(1);  dy = off(1);  end
        3'd2: begin dx = off(1);  dy = off(0);  end
        3'd3: begin dx = off(1);  dy = off(-1); end
        3'd4: begin dx = off(0);  dy = off(-1); end
        3'd5: begin dx = off(-1); dy = off(-1); end
        3'd6: begin dx = off(-1); dy = off(0);  end
        default: begin dx = off(-1); dy = off(1); end
      endcase
    end
  end

  // Offsets never exceed 2, so any off-board result shows up as the sign bit.
  assign cand_x  = $signed({1'b0, cur_x}) + dx;
  assign cand_y  = $signed({1'b0, cur_y}) + dy;
  assign cand_ok = !cand_x[CW-1] && !cand_y[CW-1];

  always_comb begin
    found     = 1'b0;
    found_dir = '0;
    for (int i = 7; i >= 0; i--) begin
      if (dir_mask[i] && (4'(i) >= dir_ptr)) begin
        found     = 1'b1;
        found_dir = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.start) state_nxt = NEXT_DIR;
      NEXT_DIR: state_nxt = found ? STEP : FIN;
      STEP:     state_nxt = cand_ok ? WAIT : NEXT_DIR;
      WAIT:     state_nxt = (rd_type == 3'd0 || rd_colour != src_colour) ? EMIT : NEXT_DIR;
      EMIT:     if (bus.mv_ready) state_nxt = ray_end ? NEXT_DIR : STEP;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_x_q    <= '0;
      src_y_q    <= '0;
      src_colour <= 1'b0;
      src_type   <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      dir        <= '0;
      dir_ptr    <= '0;
      ray_end    <= 1'b0;
      to_x       <= '0;
      to_y       <= '0;
      capture    <= 1'b0;
      victim     <= '0;
      move_count <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          src_x_q    <= bus.src_x;
          src_y_q    <= bus.src_y;
          src_colour <= bus.src_piece[PIECE_W-1];
          src_type   <= bus.src_piece[2:0];
          dir_ptr    <= '0;
          move_count <= '0;
        end
        NEXT_DIR: if (found) begin
          dir     <= found_dir;
          dir_ptr <= {1'b0, found_dir} + 4'd1;
          cur_x   <= src_x_q;
          cur_y   <= src_y_q;
        end
        STEP: if (cand_ok) begin
          cur_x <= cand_x[COORD_W-1:0];
          cur_y <= cand_y[COORD_W-1:0];
        end
        WAIT: begin
          to_x    <= cur_x;
          to_y    <= cur_y;
          capture <= (rd_type != 3'd0);
          victim  <= (rd_type != 3'd0) ? bus.rd_piece : '0;
          ray_end <= single || (rd_type != 3'd0);
        end
        EMIT: if (bus.mv_ready && move_count != '1) move_count <= move_count + COUNT_W'(1);
        default: ;
      endcase
    end
  end

  assign rd_en          = (state == STEP) && cand_ok;
  assign bus.rd_en      = rd_en;
  assign bus.rd_x       = rd_en ? cand_x[COORD_W-1:0] : '0;
  assign bus.rd_y       = rd_en ? cand_y[COORD_W-1:0] : '0;
  assign bus.busy       = (state == NEXT_DIR) || (state == STEP) || (state == WAIT) || (state == EMIT);
  assign bus.done       = (state == FIN);
  assign bus.mv_valid   = (state == EMIT);
  assign bus.mv_to_x    = to_x;
  assign bus.mv_to_y    = to_y;
  assign bus.mv_capture = capture;
  assign bus.mv_victim  = victim;
  assign bus.move_count = move_count;
endmodule
